sram_burst_reader: RTL

//   Read-side client for the 1R1W output-buffer SRAM (16K x 16). Given a start

---
 rtl/sram_burst_reader.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sram_burst_reader.sv
// Burst read client for the 1R1W output-buffer SRAM: streams a word range out over valid/ready.
// Optional checksum on the output stream is enabled by defining SRAM_BURST_SUM_EN.
module sram_burst_reader #(
  parameter int AW = 14,
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   length,
  input  logic          abort,
  output logic [AW-1:0] ReadAddress,
  input  logic [DW-1:0] ReadBus,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] sum
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   remaining_q, remaining_d;
  logic [DW-1:0] fifo_q [2];
  logic [DW-1:0] fifo_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          push;
  logic          pop;

  assign out_valid   = (cnt_q != 2'd0);
  assign out_data    = fifo_q[rd_ptr_q];
  assign pop         = out_valid & out_ready;
  assign ReadAddress = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    push        = 1'b0;

    if (abort) begin
      // Flush wins over everything, including a same-cycle start or pop; address holds.
      state_d     = IDLE;
      remaining_d = '0;
      wr_ptr_d    = 1'b0;
      rd_ptr_d    = 1'b0;
      cnt_d       = 2'd0;
      busy_d      = 1'b0;
    end else begin
      push = (state_q == READ) && (remaining_q != '0) && ((cnt_q != 2'd2) || pop);

      case (state_q)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              state_d     = READ;
              addr_d      = base_addr;
              remaining_d = length;
              busy_d      = 1'b1;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        READ: begin
          if (remaining_q == '0) state_d = DRAIN;
        end
        DRAIN: begin
          if (cnt_q == 2'd0) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      // ReadBus already reflects addr_q this cycle; capture it and advance (wraps mod 2**AW).
      if (push) begin
        fifo_d[wr_ptr_q] = ReadBus;
        wr_ptr_d         = ~wr_ptr_q;
        addr_d           = addr_q + 1'b1;
        remaining_d      = remaining_q - 1'b1;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;

      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      // NOTE: the two FIFO entries are reset because out_data is read straight from the head entry.
      fifo_q      <= '{default: '0};
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef SRAM_BURST_SUM_EN
  logic [DW-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (!abort) begin
      if ((state_q == IDLE) && start) sum_d = '0;
      else if (pop)                   sum_d = sum_q + out_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign sum = sum_q;
`else
  assign sum = '0;
`endif

endmodule
